// File: rtl/ffd_pipe.sv
// Stallable, flushable D flip-flop delay line with per-stage valid tracking.
// Bubbles never overwrite stage data, and the occupancy count is kept in a register.
module ffd_pipe #(
  parameter int               WIDTH     = 4,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           D,
  output logic [WIDTH-1:0]           Q,
  output logic                       out_valid,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       full
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [OCC_W-1:0] occ_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) data_q[i] <= RESET_VAL;
      valid_q <= '0;
      occ_q   <= '0;
    end else if (flush) begin
      // Data stays put; only the qualifiers are dropped.
      valid_q <= '0;
      occ_q   <= '0;
    end else if (en) begin
      valid_q[0] <= in_valid;
      if (in_valid) data_q[0] <= D;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) data_q[i] <= data_q[i-1];
      end
      occ_q <= occ_q + OCC_W'(in_valid) - OCC_W'(valid_q[DEPTH-1]);
    end
  end

  assign Q         = data_q[DEPTH-1];
  assign out_valid = valid_q[DEPTH-1];
  assign occupancy = occ_q;
  assign full      = (occ_q == OCC_W'(DEPTH));

endmodule

// File: tb/tb_ffd_pipe.sv
// Bench for ffd_pipe: directed scenarios plus random traffic, compared each cycle
// against an item-history model of the pipeline.
module tb_ffd_pipe;
  localparam int W  = 4;
  localparam int DP = 3;
  localparam int OW = $clog2(DP + 1);

  logic          clk = 1'b0;
  logic          reset, en, flush, in_valid;
  logic [W-1:0]  D, Q;
  logic          out_valid, full;
  logic [OW-1:0] occupancy;

  always #5 clk = ~clk;

  ffd_pipe #(.WIDTH(W), .DEPTH(DP), .RESET_VAL(4'h0)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid),
    .D(D), .Q(Q), .out_valid(out_valid), .occupancy(occupancy), .full(full)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: list of shift events since the last flush/reset (index = age in
  // enabled shifts, 0 = newest). An item of age a sits in stage a. A stage's
  // data is the newest real item that has reached it, else the value it held
  // when history was last cleared.
  typedef struct {bit v; logic [W-1:0] d;} ent_t;
  ent_t         h[$];
  logic [W-1:0] base [DP];

  function automatic logic [W-1:0] stage_data(int i);
    for (int a = i; a < h.size(); a++) if (h[a].v) return h[a].d;
    return base[i];
  endfunction

  function automatic void model_reset();
    h.delete();
    for (int i = 0; i < DP; i++) base[i] = 4'h0;
  endfunction

  function automatic void model_edge(bit e, bit f, bit iv, logic [W-1:0] d);
    ent_t x;
    if (f) begin
      for (int i = 0; i < DP; i++) base[i] = stage_data(i);
      h.delete();
    end else if (e) begin
      x.v = iv;
      x.d = d;
      h.push_front(x);
    end
  endfunction

  function automatic int exp_occ();
    int n = 0;
    for (int a = 0; a < DP && a < h.size(); a++) n += int'(h[a].v);
    return n;
  endfunction

  task automatic check_all(input string tag);
    bit ov;
    ov = (h.size() >= DP) ? h[DP-1].v : 1'b0;
    chk({tag, ".q"},    32'(Q),         32'(stage_data(DP-1)));
    chk({tag, ".ov"},   32'(out_valid), 32'(ov));
    chk({tag, ".occ"},  32'(occupancy), 32'(exp_occ()));
    chk({tag, ".full"}, 32'(full),      32'(exp_occ() == DP));
  endtask

  task automatic cycle(input string tag, input bit e, input bit f, input bit iv,
                       input logic [W-1:0] d);
    en = e; flush = f; in_valid = iv; D = d;
    @(posedge clk);
    if (reset) model_edge(e, f, iv, d);
    #1 check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b1, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic areset(input string tag);
    @(negedge clk);
    #2 reset = 1'b0;
    model_reset();
    #1 check_all({tag, ".async"});
    chk({tag, ".async_q"}, 32'(Q), 32'h0);
    chk({tag, ".async_ov"}, 32'(out_valid), 32'h0);
    cycle({tag, ".held"}, 1'b1, 1'b0, 1'b1, 4'hF);
    @(negedge clk) reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; flush = 1'b0; in_valid = 1'b0; D = '0;
    model_reset();
    #1 check_all("rst0");

    // reset held while inputs and enable toggle
    for (int i = 0; i < 4; i++) cycle("rst", 1'(i % 2 == 0), 1'b0, 1'b1, 4'hF);
    chk("rst_occ", 32'(occupancy), 32'h0);
    @(negedge clk) reset = 1'b1;
    cycle("first", 1'b1, 1'b0, 1'b1, 4'hB);
    idle("first", 2);
    chk("b_at_q", 32'(Q), 32'hB);
    chk("b_valid", 32'(out_valid), 32'h1);
    idle("drain", 2);

    // streaming
    for (int i = 1; i <= 4; i++) cycle("stream", 1'b1, 1'b0, 1'b1, 4'(i));
    chk("stream_full", 32'(full), 32'h1);
    idle("stream", 4);

    // stall
    cycle("stall_in", 1'b1, 1'b0, 1'b1, 4'h5);
    cycle("stall_in", 1'b1, 1'b0, 1'b1, 4'h6);
    for (int i = 0; i < 4; i++) cycle("stall", 1'b0, 1'b0, 1'b1, 4'hA);
    chk("stall_occ", 32'(occupancy), 32'h2);
    idle("stall_out", 4);

    // bubbles
    cycle("bub", 1'b1, 1'b0, 1'b1, 4'h7);
    cycle("bub", 1'b1, 1'b0, 1'b0, 4'hE);
    cycle("bub", 1'b1, 1'b0, 1'b1, 4'h9);
    idle("bub", 4);

    // flush of a full pipe
    for (int i = 0; i < 3; i++) cycle("fl_fill", 1'b1, 1'b0, 1'b1, 4'(i + 1));
    cycle("flush", 1'b1, 1'b1, 1'b1, 4'hC);
    chk("flush_ov", 32'(out_valid), 32'h0);
    chk("flush_q", 32'(Q), 32'h1);
    idle("postfl", 4);

    // async reset mid-stream
    cycle("mid", 1'b1, 1'b0, 1'b1, 4'h3);
    cycle("mid", 1'b1, 1'b0, 1'b1, 4'h8);
    areset("mid");
    cycle("mid_after", 1'b1, 1'b0, 1'b1, 4'h2);
    chk("mid_occ", 32'(occupancy), 32'h1);
    idle("mid_after", 3);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 149) areset("rnd");
      else cycle("rnd", $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                 1'($urandom_range(0, 1)), 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
